// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions for the write buffer and its FIFO.
//   wb_state_e : buffer sequencer states (idle, draining stores, read in flight)
//   RW_READ / RW_WRITE : encoding of the c_rw / m_rw direction bits
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2
    } wb_state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding {addr,data} store entries for the write buffer.
//   clk, rst   : clock, synchronous active-high reset (discards all entries)
//   push, din  : enqueue din at the posedge (caller guarantees !full)
//   pop        : dequeue head at the posedge (caller guarantees !empty)
//   head       : oldest entry
//   next_head  : entry behind the head, so a back-to-back drain can load it
//                in the same cycle the head is popped
//   count      : occupancy, PTR_W+1 bits so DEPTH itself is representable
//   full/empty : occupancy flags
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] next_head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    assign rd_nxt    = rd_ptr + PTR_W'(1);
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_nxt];
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/d_write_buffer.sv
// Posted-write buffer between a write-through data cache and the memory bus.
// Stores are acknowledged as soon as there is room and drained in order;
// a read miss goes to memory only once every earlier store has drained.
//   clk, rst                    : clock, synchronous active-high reset
//   c_a, c_dout, c_strobe, c_rw : cache request (address, store data, valid, dir)
//   c_din, c_ready              : load data / request complete to the cache
//   m_a, m_din, m_strobe, m_rw  : registered memory request
//   m_dout, m_ready             : memory read data / transfer done
module d_write_buffer
    import mem_bus_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] c_a,
    input  logic [31:0]        c_dout,
    output logic [31:0]        c_din,
    input  logic               c_strobe,
    input  logic               c_rw,
    output logic               c_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    input  logic [31:0]        m_dout,
    output logic               m_strobe,
    output logic               m_rw,
    input  logic               m_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int E_W   = A_WIDTH + 32;

    wb_state_e          state, state_n;
    logic [A_WIDTH-1:0] m_a_n;
    logic [31:0]        m_din_n;
    logic               m_rw_n, m_strobe_n;

    logic [E_W-1:0]     head, next_head;
    logic [PTR_W:0]     count;
    logic               full, empty;
    logic               push, pop, rd_done;

    // A full buffer refuses the store even if the head pops this cycle;
    // the store is taken the cycle after.
    assign push    = ~rst & c_strobe & (c_rw == RW_WRITE) & ~full;
    assign pop     = ~rst & (state == ST_DRAIN) & m_ready;
    assign rd_done = ~rst & (state == ST_READ) & m_ready;
    assign c_ready = push | rd_done;
    assign c_din   = m_dout;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(E_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       ({c_a, c_dout}),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_n    = state;
        m_a_n      = m_a;
        m_din_n    = m_din;
        m_rw_n     = m_rw;
        m_strobe_n = m_strobe;
        case (state)
            ST_IDLE: begin
                // A store arriving into an empty buffer is forwarded straight
                // to the bus register; it is still pushed, so the pop on
                // m_ready removes exactly this entry.
                if (!empty || push) begin
                    state_n              = ST_DRAIN;
                    {m_a_n, m_din_n}     = empty ? {c_a, c_dout} : head;
                    m_rw_n               = RW_WRITE;
                    m_strobe_n           = 1'b1;
                end else if (c_strobe && c_rw == RW_READ) begin
                    state_n    = ST_READ;
                    m_a_n      = c_a;
                    m_rw_n     = RW_READ;
                    m_strobe_n = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (count > (PTR_W+1)'(1)) begin
                        {m_a_n, m_din_n} = next_head;
                    end else begin
                        state_n    = ST_IDLE;
                        m_strobe_n = 1'b0;
                    end
                end
            end
            ST_READ: begin
                if (m_ready) begin
                    state_n    = ST_IDLE;
                    m_strobe_n = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            m_a      <= '0;
            m_din    <= '0;
            m_rw     <= RW_READ;
            m_strobe <= 1'b0;
        end else begin
            state    <= state_n;
            m_a      <= m_a_n;
            m_din    <= m_din_n;
            m_rw     <= m_rw_n;
            m_strobe <= m_strobe_n;
        end
    end

endmodule

// File: tb/tb_d_write_buffer.sv
// Bench for d_write_buffer: a behavioural memory responder with configurable
// latency, an in-order store log, and a reference memory image updated in
// cache program order so read data exposes any read/store reordering.
module tb_d_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_a, c_dout, c_din;
    logic        c_strobe, c_rw, c_ready;
    logic [31:0] m_a, m_din;
    logic [31:0] m_dout = '0;
    logic        m_strobe, m_rw;
    logic        m_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // memory responder controls
    int   mem_lat   = 0;
    bit   mem_hold  = 0;
    bit   mem_pulse = 0;
    int   wcnt      = 0;
    int   last_rd_wr_cnt = -1;

    logic [63:0] exp_wr[$];
    logic [63:0] got_wr[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] sim_mem [logic [31:0]];

    bit          hold_chk = 0;
    logic [65:0] hold_val;

    d_write_buffer #(.A_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .c_a(c_a), .c_dout(c_dout), .c_din(c_din),
        .c_strobe(c_strobe), .c_rw(c_rw), .c_ready(c_ready),
        .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
        .m_strobe(m_strobe), .m_rw(m_rw), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Background contents of never-written memory locations.
    function automatic logic [31:0] bg(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model: logs completed transfers at the edge, then drives
    // m_ready / m_dout for the new cycle 1 time unit after the edge.
    always @(posedge clk) begin
        if (hold_chk) begin
            n_cmp++;
            if ({m_strobe, m_rw, m_a, m_din} !== hold_val) begin
                n_err++;
                $display("FAIL bus_hold: got %h required %h", {m_strobe, m_rw, m_a, m_din}, hold_val);
            end
        end
        hold_chk = (m_strobe === 1'b1) && !m_ready && !rst;
        hold_val = {m_strobe, m_rw, m_a, m_din};
        if (rst) wcnt = 0;
        else if (m_strobe === 1'b1 && m_ready) begin
            if (m_rw) begin
                got_wr.push_back({m_a, m_din});
                sim_mem[m_a] = m_din;
            end else begin
                last_rd_wr_cnt = got_wr.size();
            end
            wcnt = 0;
        end else if (m_strobe === 1'b1) wcnt++;
        else wcnt = 0;
        #1;
        if (rst) m_ready = 1'b0;
        else if (mem_pulse) begin
            m_ready   = (m_strobe === 1'b1);
            mem_pulse = 0;
        end else m_ready = (m_strobe === 1'b1) && !mem_hold && (wcnt >= mem_lat);
        if (m_strobe === 1'b1 && m_rw === 1'b0)
            m_dout = sim_mem.exists(m_a) ? sim_mem[m_a] : bg(m_a);
        else
            m_dout = $urandom;
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    // Drivers: start and end 1 unit after a posedge; sample 3 units after.
    task automatic cache_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        c_a = a; c_dout = d; c_rw = 1'b1; c_strobe = 1'b1; lat = 0;
        #2;
        while (c_ready !== 1'b1 && lat < 300) begin @(posedge clk); #3; lat++; end
        if (c_ready === 1'b1) begin
            exp_wr.push_back({a, d});
            ref_mem[a] = d;
        end else lat = -1;
        @(posedge clk); #1;
        c_strobe = 1'b0;
    endtask

    task automatic cache_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        c_a = a; c_dout = $urandom; c_rw = 1'b0; c_strobe = 1'b1; lat = 0; d = 'x;
        #2;
        while (c_ready !== 1'b1 && lat < 300) begin @(posedge clk); #3; lat++; end
        if (c_ready === 1'b1) d = c_din; else lat = -1;
        @(posedge clk); #1;
        c_strobe = 1'b0;
    endtask

    task automatic check_drain(input string tag);
        int n = 0;
        @(posedge clk); #1;
        while (!(got_wr.size() >= exp_wr.size() && m_strobe === 1'b0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (got_wr.size() != exp_wr.size() || m_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL %s drain_count: got %0d stores (m_strobe=%b) required %0d", tag, got_wr.size(), m_strobe, exp_wr.size());
        end else begin
            for (int i = 0; i < exp_wr.size(); i++) begin
                n_cmp++;
                if (got_wr[i] !== exp_wr[i]) begin
                    n_err++;
                    $display("FAIL %s drain_order[%0d]: got %h required %h", tag, i, got_wr[i], exp_wr[i]);
                end
            end
        end
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h44; c_dout = 32'h55;
        repeat (2) begin
            @(posedge clk); #3;
            n_cmp++;
            if ({c_ready, m_strobe, m_rw, m_a, m_din} !== 66'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h required 0", {c_ready, m_strobe, m_rw, m_a, m_din});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; c_strobe = 1'b0;
        // An empty buffer issues nothing after reset.
        repeat (5) begin
            #2;
            n_cmp++;
            if (m_strobe !== 1'b0 || got_wr.size() != 0) begin
                n_err++;
                $display("FAIL reset_idle: got m_strobe=%b stores=%0d required 0/0", m_strobe, got_wr.size());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_write;
        int lat, n;
        mem_lat = 2; mem_hold = 0;
        cache_write(32'h10, 32'hDEADBEEF, lat);
        n_cmp++;
        if (lat !== 0) begin n_err++; $display("FAIL single_accept: got latency %0d required 0", lat); end
        #2;
        n_cmp++;
        if ({m_strobe, m_rw, m_a, m_din} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL single_bus: got %h required %h", {m_strobe, m_rw, m_a, m_din}, {1'b1, 1'b1, 32'h10, 32'hDEADBEEF});
        end
        n = 0;
        while (m_ready !== 1'b1 && n < 50) begin @(posedge clk); #3; n++; end
        n_cmp++;
        if (n !== 2) begin n_err++; $display("FAIL single_mem_wait: got %0d cycles required 2", n); end
        @(posedge clk); #3;
        n_cmp++;
        if (m_strobe !== 1'b0) begin n_err++; $display("FAIL single_strobe_drop: got %b required 0", m_strobe); end
        check_drain("single");
    endtask

    task automatic test_full;
        int lat;
        mem_hold = 1; mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            cache_write(32'h1000 + 32'(i * 4), $urandom, lat);
            n_cmp++;
            if (lat !== 0) begin n_err++; $display("FAIL full_accept[%0d]: got latency %0d required 0", i, lat); end
        end
        c_a = 32'h1010; c_dout = $urandom; c_rw = 1'b1; c_strobe = 1'b1;
        #2;
        n_cmp++;
        if (c_ready !== 1'b0) begin n_err++; $display("FAIL full_refuse: got c_ready=%b required 0", c_ready); end
        mem_pulse = 1;
        @(posedge clk); #3;
        n_cmp++;
        if ({m_ready, c_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL full_pop_cycle: got m_ready/c_ready=%b required 10", {m_ready, c_ready});
        end
        @(posedge clk); #3;
        n_cmp++;
        if (c_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_accept_after_pop: got c_ready=%b required 1", c_ready);
        end else begin
            exp_wr.push_back({c_a, c_dout});
            ref_mem[c_a] = c_dout;
        end
        @(posedge clk); #1;
        c_strobe = 1'b0; mem_hold = 0;
        check_drain("full");
    endtask

    task automatic test_read_after_write;
        int lat;
        logic [31:0] d;
        mem_lat = 1; mem_hold = 0;
        sim_mem[32'h30] = 32'h12345678;
        ref_mem[32'h30] = 32'h12345678;
        cache_write(32'h20, $urandom, lat);
        cache_write(32'h24, $urandom, lat);
        cache_read(32'h30, d, lat);
        n_cmp++;
        if (d !== 32'h12345678) begin n_err++; $display("FAIL raw_data: got %h required 12345678", d); end
        n_cmp++;
        if (last_rd_wr_cnt !== 2) begin
            n_err++;
            $display("FAIL raw_order: got %0d stores before read required 2", last_rd_wr_cnt);
        end
        // Reading back a just-posted store must see its data.
        cache_write(32'h24, 32'hCAFE0024, lat);
        cache_read(32'h24, d, lat);
        n_cmp++;
        if (d !== 32'hCAFE0024) begin n_err++; $display("FAIL raw_same_addr: got %h required cafe0024", d); end
        check_drain("raw");
    endtask

    task automatic test_read_empty;
        int lat;
        logic [31:0] d;
        mem_lat = 0; mem_hold = 0;
        cache_read(32'h40, d, lat);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL read_empty_latency: got %0d required 1", lat); end
        n_cmp++;
        if (d !== bg(32'h40)) begin n_err++; $display("FAIL read_empty_data: got %h required %h", d, bg(32'h40)); end
    endtask

    task automatic test_reset_mid_drain;
        int lat;
        mem_hold = 1; mem_lat = 0;
        for (int i = 0; i < 3; i++) cache_write(32'h100 + 32'(i * 4), $urandom, lat);
        rst = 1'b1;
        #2;
        n_cmp++;
        if (c_ready !== 1'b0) begin n_err++; $display("FAIL rst_drain_c_ready: got %b required 0", c_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        n_cmp++;
        if (m_strobe !== 1'b0) begin n_err++; $display("FAIL rst_drain_strobe: got %b required 0", m_strobe); end
        mem_hold = 0;
        for (int i = 0; i < 3; i++) ref_mem.delete(32'h100 + 32'(i * 4));
        exp_wr.delete();
        @(posedge clk); #1;
        repeat (6) begin
            #2;
            n_cmp++;
            if (m_strobe !== 1'b0 || got_wr.size() != 0) begin
                n_err++;
                $display("FAIL rst_drain_quiet: got m_strobe=%b stores=%0d required 0/0", m_strobe, got_wr.size());
            end
            @(posedge clk); #1;
        end
        cache_write(32'h200, 32'h0BADF00D, lat);
        n_cmp++;
        if (lat !== 0) begin n_err++; $display("FAIL rst_drain_new_write: got latency %0d required 0", lat); end
        check_drain("rst_drain");
    endtask

    task automatic test_random;
        int lat, cnt;
        logic [31:0] a, d, exp_d;
        for (int op = 0; op < 60; op++) begin
            mem_lat = $urandom_range(0, 3);
            a = 32'h80 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) < 7) begin
                cache_write(a, $urandom, lat);
                n_cmp++;
                if (lat < 0) begin n_err++; $display("FAIL rand_write_timeout: op %0d addr %h", op, a); end
            end else begin
                exp_d = ref_read(a);
                cnt   = exp_wr.size();
                cache_read(a, d, lat);
                n_cmp++;
                if (d !== exp_d || last_rd_wr_cnt !== cnt) begin
                    n_err++;
                    $display("FAIL rand_read: op %0d addr %h got %h after %0d stores required %h after %0d",
                             op, a, d, last_rd_wr_cnt, exp_d, cnt);
                end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        check_drain("random");
    endtask

    initial begin
        c_a = '0; c_dout = '0; c_rw = 1'b0; c_strobe = 1'b0; rst = 1'b1;
        test_reset();
        test_single_write();
        test_full();
        test_read_after_write();
        test_read_empty();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
